// File: rtl/uart_pkg.sv
// Shared definitions for the uart_txrx core.
//   uart_state_e : state encoding used by both the TX and RX FSMs
//   DATA_BITS    : payload bits per frame
//   FRAME_BITS   : start + data + stop bits per frame
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } uart_state_e;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;
endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer shared by the TX and RX paths.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear_i    : hold the count at zero
//   half_i     : target the half-bit point instead of the full period
//   tick_o     : high while the count sits at the selected target
// The count returns to zero by itself on the tick, so back-to-back bit
// periods need no extra clear cycle.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic half_i,
    output logic tick_o
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == (half_i ? HALF : FULL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent transmitter and receiver on one clock.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   tx_data_valid  : one-cycle send request, taken only when TX is idle
//   tx_data        : byte to send, latched on the accepting cycle
//   tx_active      : high from start bit through stop bit
//   tx_serial      : serial line out, idle high
//   tx_done        : one-cycle pulse after the stop bit
//   rx_serial      : asynchronous serial line in, idle high
//   rx_data_valid  : one-cycle pulse per good byte
//   rx_data        : last good byte, held until the next one
module uart_txrx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_data_valid,
    input  logic [7:0] tx_data,
    output logic       tx_active,
    output logic       tx_serial,
    output logic       tx_done,
    input  logic       rx_serial,
    output logic       rx_data_valid,
    output logic [7:0] rx_data
);
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    // ---------------- transmitter ----------------
    uart_state_e tx_state_q;
    logic [7:0]  tx_shift_q;
    logic [2:0]  tx_idx_q;
    logic        tx_serial_q, tx_active_q, tx_done_q;
    logic        tx_tick;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (tx_state_q == IDLE || tx_state_q == CLEANUP),
        .half_i  (1'b0),
        .tick_o  (tx_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= IDLE;
            tx_shift_q  <= '0;
            tx_idx_q    <= '0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            case (tx_state_q)
                IDLE: begin
                    tx_done_q   <= 1'b0;
                    tx_serial_q <= 1'b1;
                    tx_active_q <= 1'b0;
                    if (tx_data_valid) begin
                        tx_shift_q  <= tx_data;
                        tx_idx_q    <= '0;
                        tx_serial_q <= 1'b0;
                        tx_active_q <= 1'b1;
                        tx_state_q  <= START;
                    end
                end
                START: if (tx_tick) begin
                    tx_serial_q <= tx_shift_q[0];
                    tx_state_q  <= DATA;
                end
                // The latched byte shifts right so bit 0 is always the one on the line.
                DATA: if (tx_tick) begin
                    if (tx_idx_q == LAST_IDX) begin
                        tx_serial_q <= 1'b1;
                        tx_state_q  <= STOP;
                    end else begin
                        tx_idx_q    <= tx_idx_q + 3'd1;
                        tx_serial_q <= tx_shift_q[1];
                        tx_shift_q  <= tx_shift_q >> 1;
                    end
                end
                STOP: if (tx_tick) begin
                    tx_done_q   <= 1'b1;
                    tx_active_q <= 1'b0;
                    tx_state_q  <= CLEANUP;
                end
                CLEANUP: begin
                    tx_done_q  <= 1'b0;
                    tx_state_q <= IDLE;
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    assign tx_serial = tx_serial_q;
    assign tx_active = tx_active_q;
    assign tx_done   = tx_done_q;

    // ---------------- receiver ----------------
    // Two-flop synchronizer; reset to the idle-high line level.
    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_serial;
            rx_sync_q <= rx_meta_q;
        end
    end

    uart_state_e rx_state_q;
    logic [7:0]  rx_shift_q, rx_data_q;
    logic [2:0]  rx_idx_q;
    logic        rx_valid_q;
    logic        rx_tick;

    // START waits only to mid-bit; from there every full period lands mid-bit.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (rx_state_q == IDLE || rx_state_q == CLEANUP),
        .half_i  (rx_state_q == START),
        .tick_o  (rx_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= IDLE;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_idx_q   <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            case (rx_state_q)
                IDLE: begin
                    rx_valid_q <= 1'b0;
                    rx_idx_q   <= '0;
                    if (!rx_sync_q) rx_state_q <= START;
                end
                // A line that is high again at mid-bit was only a glitch.
                START: if (rx_tick) rx_state_q <= rx_sync_q ? IDLE : DATA;
                DATA: if (rx_tick) begin
                    rx_shift_q[rx_idx_q] <= rx_sync_q;
                    if (rx_idx_q == LAST_IDX) rx_state_q <= STOP;
                    else                      rx_idx_q   <= rx_idx_q + 3'd1;
                end
                // A low stop bit is a framing error: the byte is dropped silently.
                STOP: if (rx_tick) begin
                    if (rx_sync_q) begin
                        rx_data_q  <= rx_shift_q;
                        rx_valid_q <= 1'b1;
                    end
                    rx_state_q <= CLEANUP;
                end
                CLEANUP: begin
                    rx_valid_q <= 1'b0;
                    rx_state_q <= IDLE;
                end
                default: rx_state_q <= IDLE;
            endcase
        end
    end

    assign rx_data_valid = rx_valid_q;
    assign rx_data       = rx_data_q;
endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx: one instance at 8 clocks/bit for most
// sequences (with a mux choosing loopback or a driven RX line) and one at
// 217 clocks/bit wired in direct loopback.
module tb_uart_txrx;
    localparam int C  = 8;
    localparam int CL = 217;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // fast instance
    logic       tx_data_valid, tx_active, tx_serial, tx_done, rx_serial, rx_data_valid;
    logic [7:0] tx_data, rx_data;
    logic       loop_en, rx_drv;
    assign rx_serial = loop_en ? tx_serial : rx_drv;

    uart_txrx #(.CLKS_PER_BIT(C)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data_valid (tx_data_valid),
        .tx_data       (tx_data),
        .tx_active     (tx_active),
        .tx_serial     (tx_serial),
        .tx_done       (tx_done),
        .rx_serial     (rx_serial),
        .rx_data_valid (rx_data_valid),
        .rx_data       (rx_data)
    );

    // 115200-baud instance, hard loopback
    logic       l_tx_data_valid, l_tx_active, l_tx_serial, l_tx_done, l_rx_data_valid;
    logic [7:0] l_tx_data, l_rx_data;

    uart_txrx #(.CLKS_PER_BIT(CL)) dut_l (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data_valid (l_tx_data_valid),
        .tx_data       (l_tx_data),
        .tx_active     (l_tx_active),
        .tx_serial     (l_tx_serial),
        .tx_done       (l_tx_done),
        .rx_serial     (l_tx_serial),
        .rx_data_valid (l_rx_data_valid),
        .rx_data       (l_rx_data)
    );

    int tests = 0;
    int fails = 0;
    int done_cnt = 0, rxv_cnt = 0, l_rxv_cnt = 0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (rx_data_valid) begin
            rxv_cnt++;
            rx_q.push_back(rx_data);
        end
        if (l_rx_data_valid) l_rxv_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // advance n clocks, leaving time 1 unit past the last rising edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] b);
        tx_data = b;
        tx_data_valid = 1'b1;
        cyc(1);
        tx_data_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!tx_done && k < 20 * C) begin
            cyc(1);
            k++;
        end
        chk(name, tx_done, 1'b1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            cyc(C);
        end
        rx_drv = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_cnt;
        logic [7:0] exp_rx;
    } rx_vec_t;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rx_vec_t    vt[6];
        logic [9:0] eb;
        int         k, n0, d0, bit_err, inact;

        vt[0] = '{8'h12, 1'b1, 1, 8'h12};
        vt[1] = '{8'h80, 1'b1, 1, 8'h80};
        vt[2] = '{8'hC3, 1'b0, 0, 8'h80};  // bad stop: previous byte kept
        vt[3] = '{8'hE7, 1'b1, 1, 8'hE7};
        vt[4] = '{8'h00, 1'b1, 1, 8'h00};
        vt[5] = '{8'hFF, 1'b1, 1, 8'hFF};

        tx_data_valid = 1'b0; tx_data = '0;
        l_tx_data_valid = 1'b0; l_tx_data = '0;
        loop_en = 1'b0; rx_drv = 1'b1;

        // ---- reset values ----
        #22;
        chk("rst_tx_serial", tx_serial, 1'b1);
        chk("rst_tx_active", tx_active, 1'b0);
        chk("rst_tx_done", tx_done, 1'b0);
        chk("rst_rx_valid", rx_data_valid, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_l_tx_serial", l_tx_serial, 1'b1);
        cyc(1);
        rst_n = 1'b1;
        cyc(3);

        // ---- 217 clocks/bit loopback, 0x3F ----
        l_tx_data = 8'h3F;
        l_tx_data_valid = 1'b1;
        k = 0;
        cyc(1);
        l_tx_data_valid = 1'b0;
        k = 1;
        while (!l_tx_done && k < 12 * CL) begin
            cyc(1);
            k++;
        end
        chk("l_done_latency", k, 10 * CL + 1);
        chk("l_rx_count", l_rxv_cnt, 1);
        chk("l_rx_data", l_rx_data, 8'h3F);

        // ---- TX waveform for 0x01, with a mid-frame request to be ignored ----
        loop_en = 1'b1;
        d0 = done_cnt;
        eb = 10'b10_0000_0010;  // index 0 is the start bit
        send8(8'h01);
        inact = 0;
        for (int j = 0; j < 10; j++) begin
            bit_err = 0;
            for (int c = 0; c < C; c++) begin
                if (tx_serial !== eb[j]) bit_err++;
                if (tx_active !== 1'b1) inact++;
                if (j == 3 && c == 0) begin tx_data = 8'hFF; tx_data_valid = 1'b1; end
                if (j == 3 && c == 1) tx_data_valid = 1'b0;
                cyc(1);
            end
            chk($sformatf("txwave_bit%0d_errs", j), bit_err, 0);
        end
        chk("txwave_active_cycles", inact, 0);
        chk("txwave_done_at_end", tx_done, 1'b1);
        chk("txwave_active_low_at_end", tx_active, 1'b0);
        cyc(3 * C);
        chk("txwave_no_queued_frame", tx_active, 1'b0);
        chk("txwave_done_count", done_cnt - d0, 1);
        chk("txwave_loop_rx", rx_data, 8'h01);

        // ---- back-to-back loopback ----
        rx_q.delete();
        send8(8'h00);
        wait_done("b2b_done0");
        cyc(1);
        send8(8'hFF);
        wait_done("b2b_done1");
        cyc(1);
        send8(8'hA5);
        wait_done("b2b_done2");
        cyc(2);
        chk("b2b_count", rx_q.size(), 3);
        chk("b2b_byte0", rx_q.size() > 0 ? rx_q[0] : 8'hxx, 8'h00);
        chk("b2b_byte1", rx_q.size() > 1 ? rx_q[1] : 8'hxx, 8'hFF);
        chk("b2b_byte2", rx_q.size() > 2 ? rx_q[2] : 8'hxx, 8'hA5);

        // ---- directly driven RX frames ----
        loop_en = 1'b0;
        cyc(2 * C);
        for (int i = 0; i < 6; i++) begin
            n0 = rxv_cnt;
            rx_frame(vt[i].data, vt[i].stop);
            cyc(2 * C);
            chk($sformatf("rxvec%0d_count", i), rxv_cnt - n0, vt[i].exp_cnt);
            chk($sformatf("rxvec%0d_data", i), rx_data, vt[i].exp_rx);
        end

        // ---- short start glitch, then a real frame ----
        n0 = rxv_cnt;
        rx_drv = 1'b0;
        cyc(C / 2 - 2);
        rx_drv = 1'b1;
        cyc(2 * C);
        chk("glitch_no_valid", rxv_cnt - n0, 0);
        rx_frame(8'h5A, 1'b1);
        cyc(2 * C);
        chk("glitch_next_count", rxv_cnt - n0, 1);
        chk("glitch_next_data", rx_data, 8'h5A);

        // ---- reset mid-frame on both TX and RX ----
        loop_en = 1'b1;
        d0 = done_cnt;
        n0 = rxv_cnt;
        send8(8'h96);
        cyc(4 * C + 3);
        chk("midrst_pre_active", tx_active, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_serial", tx_serial, 1'b1);
        chk("midrst_tx_active", tx_active, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(12 * C);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_valid", rxv_cnt - n0, 0);
        send8(8'h3F);
        wait_done("midrst_next_done");
        cyc(2);
        chk("midrst_next_count", rxv_cnt - n0, 1);
        chk("midrst_next_data", rx_data, 8'h3F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_txrx.md
Name: uart_txrx

Overview:
- Full-duplex 8N1 UART core: independent transmitter and receiver sharing one clock.
- Bit period is a fixed number of clocks; no parity and no FIFO.
- Sits between a byte-wide parallel interface and a pair of serial pins.
- In loopback, tx_serial feeds rx_serial directly or through an idle-high mux.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200 baud); legal range ≥ 4.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_data_valid  in  1  one-cycle request to send tx_data; only accepted when transmitter idle.
- tx_data  in  8  byte to send, sampled on the accepting cycle.
- tx_active  out  1  high while a frame is on the line (start through stop bit).
- tx_serial  out  1  serial output; idle high.
- tx_done  out  1  one-cycle pulse after the stop bit completes.
- rx_serial  in  1  asynchronous serial input; idle high.
- rx_data_valid  out  1  one-cycle pulse when a good byte is received.
- rx_data  out  8  last received byte; held until the next good byte.

Behaviour:
- Frame format:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit lasts exactly CLKS_PER_BIT clocks.
- Reset values (asynchronous, immediate): tx_serial=1, tx_active=0, tx_done=0, rx_data_valid=0, rx_data=0; both FSMs return to IDLE.
- Reset mid-frame aborts the frame; no done or valid pulse is produced.
- TX FSM: IDLE → START → DATA → STOP → CLEANUP → IDLE.
  - IDLE: tx_serial=1, tx_active=0. On tx_data_valid=1, latch tx_data and go to START.
  - START: on the next clock, tx_serial=0 and tx_active=1; hold for CLKS_PER_BIT clocks.
  - DATA: bit index 0..7; tx_serial=latched[index], each held CLKS_PER_BIT clocks; index wraps 7 → exit.
  - STOP: tx_serial=1 for CLKS_PER_BIT clocks.
  - CLEANUP: single cycle; tx_done=1, tx_active=0; then IDLE.
  - Line frame length is exactly 10*CLKS_PER_BIT clocks.
  - tx_data_valid outside IDLE is ignored; no queuing.
  - The earliest next accept is the cycle after CLEANUP.
- RX input: two-flop synchronizer on rx_serial (2-cycle latency); FSM uses the synchronized value.
- RX FSM: IDLE → START → DATA → STOP → CLEANUP → IDLE.
  - IDLE: wait for synchronized line = 0.
  - START: count (CLKS_PER_BIT-1)/2 clocks to mid-bit.
    - If the line is still 0, reset the counter and go to DATA.
    - Otherwise it is a glitch: return to IDLE, no output.
  - DATA: wait CLKS_PER_BIT clocks, then sample into shift position index 0..7 (LSB first). After index 7, go to STOP.
  - STOP: wait CLKS_PER_BIT clocks and sample.
    - If 1, update rx_data with the assembled byte and assert rx_data_valid for exactly one cycle (entering CLEANUP).
    - If 0, it is a framing error: discard the byte, rx_data unchanged, no pulse.
  - CLEANUP: one cycle, then IDLE. Reception is ready again mid-stop-bit, so back-to-back frames are received.
- Counters:
  - Bit-period counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and then clears.
  - Bit index is 3 bits.
- TX and RX are fully independent; simultaneous activity is legal.

Decomposition:
- uart_pkg holds:
  - the state enum typedef (IDLE, START, DATA, STOP, CLEANUP), shared by both FSMs;
  - localparams DATA_BITS=8, FRAME_BITS=10.
- One sub-module: uart_bit_timer.
  - Parameter CLKS_PER_BIT.
  - Inputs clear and a half-period select.
  - Output tick pulses when the count reaches the target.
  - Instantiated once in TX and once in RX.

Test Plan:
- Loopback, CLKS_PER_BIT=217: pulse tx_data_valid with tx_data=8'h3F → rx_data_valid pulses once; rx_data=8'h3F; tx_done pulses 10*217+1 clocks after accept.
- Loopback, CLKS_PER_BIT=8: send 8'h00, 8'hFF, 8'hA5 back-to-back (each on tx_done) → three rx_data_valid pulses with matching bytes, in order.
- TX waveform check, CLKS_PER_BIT=8, byte 8'h01 → tx_serial reads 0,1,0,0,0,0,0,0,0,1, each 8 clocks; tx_active high for 80 clocks.
- Drive rx_serial low for CLKS_PER_BIT/2-2 clocks then high → no rx_data_valid; RX back in IDLE; a following valid frame 8'h5A is received correctly.
- Frame with stop bit 0 (byte 8'hC3) → no rx_data_valid; rx_data keeps its previous value.
- Assert rst_n=0 mid-DATA during TX and during RX → tx_serial=1 and tx_active=0 immediately; no tx_done or rx_data_valid; the next frame 8'h3F passes normally.
